// File: rtl/data_mem_sized.sv
// Sized RV32I data memory: B/H/W loads and stores with wait states, a Ready/Busy
// handshake, and misalignment/access-fault reporting instead of corrupting state.
module data_mem_sized #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Busy,
  output logic        Misaligned,
  output logic        AccessFault
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WS3 = 3'(WAIT_STATES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        flt_q, flt_d;
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] mem_d [DEPTH_WORDS];

  // With zero wait states the commit happens on the acceptance edge, so the
  // decode looks at the live inputs in IDLE and the captured request otherwise.
  logic [31:0] cur_addr, cur_wdata, word, word_sh, ld_val, st_val, st_data;
  logic [2:0]  cur_f3;
  logic        cur_we, legal, oob, misal, fault, mis, commit;
  logic [AW-1:0] idx;
  logic [3:0]  be;

  always_comb begin
    cur_addr  = (state_q == S_IDLE) ? Address   : addr_q;
    cur_wdata = (state_q == S_IDLE) ? WriteData : wdata_q;
    cur_f3    = (state_q == S_IDLE) ? Funct3    : f3_q;
    cur_we    = (state_q == S_IDLE) ? MemWrite  : we_q;
    idx       = cur_addr[AW+1:2];
    oob       = |cur_addr[31:AW+2];
    word      = mem_q[idx];
    word_sh   = word >> {cur_addr[1:0], 3'b000};

    legal = cur_we ? (cur_f3 inside {3'b000, 3'b001, 3'b010})
                   : (cur_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    case (cur_f3)
      3'b001, 3'b101: misal = cur_addr[0];
      3'b010:         misal = |cur_addr[1:0];
      default:        misal = 1'b0;
    endcase
    fault = !legal || oob;
    mis   = !fault && misal;

    case (cur_f3)
      3'b000:  ld_val = {{24{word_sh[7]}}, word_sh[7:0]};
      3'b001:  ld_val = {{16{word_sh[15]}}, word_sh[15:0]};
      3'b010:  ld_val = word;
      3'b100:  ld_val = {24'b0, word_sh[7:0]};
      3'b101:  ld_val = {16'b0, word_sh[15:0]};
      default: ld_val = word;
    endcase

    case (cur_f3)
      3'b000:  begin be = 4'b0001 << cur_addr[1:0]; st_data = {4{cur_wdata[7:0]}}; end
      3'b001:  begin be = cur_addr[1] ? 4'b1100 : 4'b0011; st_data = {2{cur_wdata[15:0]}}; end
      default: begin be = 4'b1111; st_data = cur_wdata; end
    endcase
    for (int b = 0; b < 4; b++)
      st_val[8*b +: 8] = be[b] ? st_data[8*b +: 8] : word[8*b +: 8];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    we_d    = we_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: if (MemRead || MemWrite) begin
        addr_d  = Address;
        wdata_d = WriteData;
        f3_d    = Funct3;
        we_d    = MemWrite;
        if (WAIT_STATES == 0) begin
          state_d = S_DONE;
          commit  = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WS3 - 3'd1;
        end
      end
      S_WAIT: if (cnt_q == 3'd0) begin
        state_d = S_DONE;
        commit  = 1'b1;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Flags only live for the single DONE cycle.
    mis_d   = commit && mis;
    flt_d   = commit && fault;
    rdata_d = rdata_q;
    if (commit && !cur_we && !fault && !mis) rdata_d = ld_val;
    mem_d = mem_q;
    if (commit && cur_we && !fault && !mis) mem_d[idx] = st_val;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      flt_q   <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      flt_q   <= flt_d;
      mem_q   <= mem_d;
    end
  end

  assign ReadData    = rdata_q;
  assign Ready       = (state_q == S_DONE);
  assign Busy        = (state_q != S_IDLE);
  assign Misaligned  = mis_q;
  assign AccessFault = flt_q;
endmodule

// File: tb/tb_data_mem_sized.sv
// Directed bench for data_mem_sized: scoreboard of expected completions popped on Ready,
// plus a WAIT_STATES=3 instance for handshake throughput.
module tb_data_mem_sized;
  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Address, WriteData, ReadData;
  logic        MemRead, MemWrite, Ready, Busy, Misaligned, AccessFault;
  logic [2:0]  Funct3;

  logic [31:0] Address3, WriteData3, ReadData3;
  logic        MemRead3, MemWrite3, Ready3, Busy3, Misaligned3, AccessFault3;
  logic [2:0]  Funct3_3;

  always #5 CLK = ~CLK;

  data_mem_sized #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_dut (
    .CLK(CLK), .RST(RST), .Address(Address), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .ReadData(ReadData), .Ready(Ready), .Busy(Busy),
    .Misaligned(Misaligned), .AccessFault(AccessFault));

  data_mem_sized #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_dut3 (
    .CLK(CLK), .RST(RST), .Address(Address3), .WriteData(WriteData3),
    .MemRead(MemRead3), .MemWrite(MemWrite3), .Funct3(Funct3_3),
    .ReadData(ReadData3), .Ready(Ready3), .Busy(Busy3),
    .Misaligned(Misaligned3), .AccessFault(AccessFault3));

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        flt;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_rd  = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Completion monitor: every Ready must match the oldest outstanding request.
  always @(negedge CLK) begin
    if (!RST && Ready) begin
      chk("ready_has_request", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.tag, "_rd"},  ReadData, e.rd);
        chk({e.tag, "_mis"}, {31'b0, Misaligned}, {31'b0, e.mis});
        chk({e.tag, "_flt"}, {31'b0, AccessFault}, {31'b0, e.flt});
      end
    end
    if (Misaligned || AccessFault) chk("flag_only_with_ready", {31'b0, Ready}, 32'd1);
  end

  // One access on u_dut (WAIT_STATES=1). Loads that succeed update the expected
  // ReadData; stores and faulting accesses must leave it unchanged.
  task automatic access(input bit wr, input bit rd_too, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input bit emis, input bit eflt, input bit poke, input string tag);
    exp_t e;
    int   n;
    e.rd  = (!wr && !emis && !eflt) ? exp_rd : last_rd;
    e.mis = emis;
    e.flt = eflt;
    e.tag = tag;
    last_rd = e.rd;
    @(negedge CLK);
    Address = a; WriteData = wd; Funct3 = f3;
    MemWrite = wr; MemRead = !wr || rd_too;
    sb_q.push_back(e);
    @(posedge CLK); #1;
    // Scramble inputs after acceptance: the captured request must be used.
    MemRead = 1'b0; MemWrite = 1'b0;
    Address = 32'hFFFF_FFFF; WriteData = ~wd; Funct3 = 3'b111;
    chk({tag, "_busy"}, {31'b0, Busy}, 32'd1);
    if (poke) begin
      MemRead = 1'b1; Address = 32'h20; Funct3 = 3'b010;
    end
    n = 0;
    while (!Ready && n < 10) begin
      @(posedge CLK); #1;
      MemRead = 1'b0;
      n++;
    end
    // Ready shows WAIT_STATES+1 cycles after the request is presented.
    chk({tag, "_latency"}, n, 32'd1);
    @(posedge CLK); #1;
  endtask

  int ready_cyc[$];

  initial begin
    RST = 1'b1; Address = '0; WriteData = '0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b010;
    Address3 = '0; WriteData3 = '0; MemRead3 = 1'b0; MemWrite3 = 1'b0; Funct3_3 = 3'b010;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy",  {31'b0, Busy}, 32'd0);
    chk("rst_ready", {31'b0, Ready}, 32'd0);
    chk("rst_rd",    ReadData, 32'h0);
    chk("rst_flags", {30'b0, Misaligned, AccessFault}, 32'd0);
    @(negedge CLK); RST = 1'b0;

    access(0, 0, 3'b010, 32'h10, 0, 32'h0000_0000, 0, 0, 0, "lw_after_reset");

    access(1, 0, 3'b010, 32'h20, 32'h8765_43A1, 0, 0, 0, 0, "sw_20");
    access(1, 0, 3'b000, 32'h22, 32'h1234_56FF, 0, 0, 0, 0, "sb_22");
    access(0, 0, 3'b010, 32'h20, 0, 32'h87FF_43A1, 0, 0, 0, "lw_20");
    access(0, 0, 3'b000, 32'h20, 0, 32'hFFFF_FFA1, 0, 0, 0, "lb_20");
    access(0, 0, 3'b100, 32'h20, 0, 32'h0000_00A1, 0, 0, 0, "lbu_20");
    access(0, 0, 3'b001, 32'h22, 0, 32'hFFFF_87FF, 0, 0, 0, "lh_22");
    access(0, 0, 3'b101, 32'h22, 0, 32'h0000_87FF, 0, 0, 0, "lhu_22");

    access(1, 0, 3'b010, 32'h30, 32'h1234_5678, 0, 0, 0, 0, "sw_30");
    access(1, 0, 3'b001, 32'h31, 32'h0000_BEEF, 0, 1, 0, 0, "sh_31_mis");
    access(0, 0, 3'b010, 32'h32, 0, 0, 1, 0, 0, "lw_32_mis");
    access(0, 0, 3'b010, 32'h30, 0, 32'h1234_5678, 0, 0, 0, "lw_30");

    access(0, 0, 3'b010, 32'h400, 0, 0, 0, 1, 0, "lw_400_flt");
    access(0, 0, 3'b010, 32'h402, 0, 0, 0, 1, 0, "lw_402_flt_over_mis");
    access(1, 0, 3'b100, 32'h30, 32'hFFFF_FFFF, 0, 0, 1, 0, "st_f3_100_flt");
    access(0, 0, 3'b010, 32'h30, 0, 32'h1234_5678, 0, 0, 0, "lw_30_unchanged");

    // Request pulsed while Busy must vanish without a second Ready.
    access(0, 0, 3'b010, 32'h20, 0, 32'h87FF_43A1, 0, 0, 1, "lw_with_poke");
    repeat (4) @(posedge CLK);
    #1;
    chk("poke_ignored_busy", {31'b0, Busy}, 32'd0);
    chk("poke_ignored_sb", 32'(sb_q.size()), 32'd0);

    access(1, 1, 3'b010, 32'h50, 32'hCAFE_F00D, 0, 0, 0, 0, "rw_both_store");
    access(1, 0, 3'b001, 32'h52, 32'h0000_1234, 0, 0, 0, 0, "sh_52");
    access(0, 0, 3'b010, 32'h50, 0, 32'h1234_F00D, 0, 0, 0, "lw_50");

    // Reset while the store sits in WAIT: no write, no Ready.
    @(negedge CLK);
    Address = 32'h40; WriteData = 32'hDEAD_BEEF; Funct3 = 3'b010; MemWrite = 1'b1;
    @(posedge CLK); #1;
    MemWrite = 1'b0;
    chk("midrst_accepted", {31'b0, Busy}, 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("midrst_busy", {31'b0, Busy}, 32'd0);
    chk("midrst_ready", {31'b0, Ready}, 32'd0);
    chk("midrst_rd", ReadData, 32'h0);
    @(negedge CLK); RST = 1'b0;
    last_rd = 32'h0;
    access(0, 0, 3'b010, 32'h40, 0, 32'h0000_0000, 0, 0, 0, "lw_40_after_rst");

    // Held MemRead on the 3-wait-state instance: one Ready every 5 cycles.
    @(negedge CLK); MemRead3 = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(posedge CLK); #1;
      if (Ready3) ready_cyc.push_back(c);
    end
    MemRead3 = 1'b0;
    chk("ws3_ready_count", 32'(ready_cyc.size()), 32'd5);
    if (ready_cyc.size() > 0) chk("ws3_first_ready", 32'(ready_cyc[0]), 32'd4);
    for (int i = 1; i < ready_cyc.size(); i++)
      chk("ws3_period", 32'(ready_cyc[i] - ready_cyc[i-1]), 32'd5);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
